// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// structs -- shared types for the instruction fetch unit.
//   rv32i_word      : 32-bit machine word (address or instruction)
//   i_queue_data_t  : one instruction-queue entry {pc, instr}
//   fetch_state_t   : fetch FSM state (IDLE, REQ, DROP)
// -----------------------------------------------------------------------------
package structs;

    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } i_queue_data_t;

    // IDLE : no request outstanding
    // REQ  : request outstanding, response will be enqueued
    // DROP : request outstanding but squashed by a flush; response discarded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage : structs

// File: rtl/fetch_queue_circ_fifo.sv
// -----------------------------------------------------------------------------
// circ_fifo -- circular FIFO with synchronous clear, generic entry type.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_enq      : push i_enq_data at the tail (ignored when full)
//   i_enq_data : entry to push
//   i_deq      : pop the head entry (ignored when empty)
//   i_clr      : empty the FIFO; overrides enqueue and dequeue
//   o_head     : head entry, combinational
//   o_count    : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module circ_fifo
    import structs::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = i_queue_data_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_enq,
    input  T                         i_enq_data,
    input  logic                     i_deq,
    input  logic                     i_clr,
    output T                         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_head;
    logic [AW-1:0]  r_tail;
    logic [CW-1:0]  r_count;

    logic w_enq;
    logic w_deq;

    assign w_enq = i_enq && (r_count != CW'(DEPTH));
    assign w_deq = i_deq && (r_count != '0);

    // Power-of-two depth: pointers wrap modulo DEPTH by natural overflow.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + AW'(1);
            if (w_deq) r_head <= r_head + AW'(1);
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end

    // NOTE: the storage array has no reset; only the pointers and count
    // decide which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_enq && !i_clr) r_mem[r_tail] <= i_enq_data;
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule : circ_fifo

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue -- instruction fetcher feeding a decoder-side instruction queue.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   inst_read     : I-cache read request, high until inst_resp
//   inst_addr     : I-cache address (fetch PC)
//   inst_resp     : I-cache response strobe
//   inst_rdata    : instruction word, valid with inst_resp
//   flush         : one-cycle redirect request
//   flush_pc      : redirect target
//   iqueue_read   : decoder dequeue strobe
//   iqueue_o      : head entry {pc, instr}
//   iqueue_valid  : queue non-empty
//   iqueue_count  : queue occupancy
// -----------------------------------------------------------------------------
module fetch_queue
    import structs::*;
#(
    parameter int        DEPTH    = 8,
    parameter rv32i_word RESET_PC = 32'h0000_0060
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     inst_read,
    output logic [31:0]              inst_addr,
    input  logic                     inst_resp,
    input  logic [31:0]              inst_rdata,
    input  logic                     flush,
    input  logic [31:0]              flush_pc,
    input  logic                     iqueue_read,
    output i_queue_data_t            iqueue_o,
    output logic                     iqueue_valid,
    output logic [$clog2(DEPTH):0]   iqueue_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  r_state;
    rv32i_word     r_pc;
    rv32i_word     r_pend_pc;

    logic          w_enq;
    logic          w_deq;
    logic [CW-1:0] w_post_count;
    i_queue_data_t w_enq_data;

    // A response is kept only in REQ and only when no flush squashes it.
    assign w_enq = (r_state == REQ) && inst_resp && !flush;
    // Dequeue is suppressed by flush through the FIFO clear.
    assign w_deq = iqueue_read && iqueue_valid;

    // Occupancy after this edge, used to decide whether to keep fetching.
    assign w_post_count = iqueue_count + CW'(w_enq) - CW'(w_deq);

    assign w_enq_data = '{pc: r_pc, instr: inst_rdata};

    circ_fifo #(
        .DEPTH (DEPTH),
        .T     (i_queue_data_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_enq      (w_enq),
        .i_enq_data (w_enq_data),
        .i_deq      (w_deq),
        .i_clr      (flush),
        .o_head     (iqueue_o),
        .o_count    (iqueue_count)
    );

    assign iqueue_valid = (iqueue_count != '0);
    assign inst_read    = (r_state != IDLE);
    assign inst_addr    = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_pend_pc <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (flush)
                        r_pc <= flush_pc;
                    else if (iqueue_count < CW'(DEPTH))
                        r_state <= REQ;
                end
                REQ: begin
                    if (flush && inst_resp) begin
                        r_pc    <= flush_pc;
                        r_state <= IDLE;
                    end else if (flush) begin
                        // Request stays on the bus; remember where to go next.
                        r_pend_pc <= flush_pc;
                        r_state   <= DROP;
                    end else if (inst_resp) begin
                        r_pc <= r_pc + 32'd4;
                        if (w_post_count >= CW'(DEPTH)) r_state <= IDLE;
                    end
                end
                DROP: begin
                    if (inst_resp) begin
                        // A flush arriving with the squashed response is the newest target.
                        r_pc    <= flush ? flush_pc : r_pend_pc;
                        r_state <= IDLE;
                    end else if (flush) begin
                        r_pend_pc <= flush_pc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import structs::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            inst_read;
    logic [31:0]     inst_addr;
    logic            inst_resp = 1'b0;
    logic [31:0]     inst_rdata = '0;
    logic            flush = 1'b0;
    logic [31:0]     flush_pc = '0;
    logic            iqueue_read = 1'b0;
    i_queue_data_t   iqueue_o;
    logic            iqueue_valid;
    logic [CW-1:0]   iqueue_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue contents plus "request outstanding" and
    // "outstanding request is squashed" flags.
    i_queue_data_t m_q[$];
    logic [31:0]   m_pc;
    logic [31:0]   m_pend;
    bit            m_busy;
    bit            m_drop;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0060)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_read    (inst_read),
        .inst_addr    (inst_addr),
        .inst_resp    (inst_resp),
        .inst_rdata   (inst_rdata),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .iqueue_read  (iqueue_read),
        .iqueue_o     (iqueue_o),
        .iqueue_valid (iqueue_valid),
        .iqueue_count (iqueue_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance one edge, update the model, then
    // return 1 time unit after the edge with inputs idle.
    task automatic step(input logic s_rst, input logic s_resp, input logic s_flush,
                        input logic s_read, input logic [31:0] s_fpc,
                        input logic [31:0] s_rdata);
        int sz;
        bit resp_eff;
        rst = s_rst; inst_resp = s_resp; flush = s_flush;
        iqueue_read = s_read; flush_pc = s_fpc; inst_rdata = s_rdata;
        @(posedge clk);
        if (s_rst) begin
            m_q.delete(); m_pc = 32'h60; m_pend = '0; m_busy = 0; m_drop = 0;
        end else begin
            sz = m_q.size();
            resp_eff = s_resp && m_busy;
            if (s_flush) m_q.delete();
            else if (s_read && sz > 0) void'(m_q.pop_front());
            if (!m_busy) begin
                if (s_flush) m_pc = s_fpc;
                else if (sz < DEPTH) m_busy = 1;
            end else if (!m_drop) begin
                if (s_flush && resp_eff) begin
                    m_pc = s_fpc; m_busy = 0;
                end else if (s_flush) begin
                    m_pend = s_fpc; m_drop = 1;
                end else if (resp_eff) begin
                    m_q.push_back('{pc: m_pc, instr: s_rdata});
                    m_pc = m_pc + 32'd4;
                    if (m_q.size() >= DEPTH) m_busy = 0;
                end
            end else begin
                if (resp_eff) begin
                    m_pc = s_flush ? s_fpc : m_pend; m_busy = 0; m_drop = 0;
                end else if (s_flush) begin
                    m_pend = s_fpc;
                end
            end
        end
        #1;
        rst = 1'b0; inst_resp = 1'b0; flush = 1'b0; iqueue_read = 1'b0;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, '0, '0);
        step(1, 0, 0, 0, '0, '0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (inst_read !== 1'b0) begin n_errors++; $display("FAIL reset_read: got %b want 0", inst_read); end
        n_checks++; if (inst_addr !== 32'h60) begin n_errors++; $display("FAIL reset_addr: got %h want 00000060", inst_addr); end
        n_checks++; if (iqueue_count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", iqueue_count); end
        n_checks++; if (iqueue_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", iqueue_valid); end
    endtask

    task automatic test_basic_fetch();
        logic [31:0] words [3];
        words[0] = 32'h0000_0013; words[1] = 32'h0010_0093; words[2] = 32'h0020_0113;
        do_reset();
        step(0, 0, 0, 0, '0, '0);
        n_checks++; if (inst_read !== 1'b1 || inst_addr !== 32'h60) begin n_errors++; $display("FAIL first_req: got read=%b addr=%h want 1 00000060", inst_read, inst_addr); end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, '0, words[i]);
            n_checks++; if (inst_addr !== 32'h64 + 32'(4 * i)) begin n_errors++; $display("FAIL fetch_addr%0d: got %h want %h", i, inst_addr, 32'h64 + 32'(4 * i)); end
        end
        n_checks++; if (iqueue_count !== CW'(3) || iqueue_valid !== 1'b1) begin n_errors++; $display("FAIL basic_count: got %0d/%b want 3/1", iqueue_count, iqueue_valid); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (iqueue_o.pc !== 32'h60 + 32'(4 * i) || iqueue_o.instr !== words[i]) begin n_errors++; $display("FAIL basic_head%0d: got %h/%h want %h/%h", i, iqueue_o.pc, iqueue_o.instr, 32'h60 + 32'(4 * i), words[i]); end
            step(0, 0, 0, 1, '0, '0);
        end
        n_checks++; if (iqueue_valid !== 1'b0 || iqueue_count !== '0) begin n_errors++; $display("FAIL basic_drain: got %b/%0d want 0/0", iqueue_valid, iqueue_count); end
    endtask

    task automatic test_full();
        do_reset();
        step(0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 6; i++) step(0, inst_read, 0, 0, '0, 32'hC0DE_0000 + 32'(i));
        n_checks++; if (inst_read !== 1'b0 || iqueue_count !== CW'(4)) begin n_errors++; $display("FAIL full_stop: got read=%b count=%0d want 0/4", inst_read, iqueue_count); end
        step(0, 0, 0, 1, '0, '0);
        n_checks++; if (iqueue_count !== CW'(3) || iqueue_o.pc !== 32'h64) begin n_errors++; $display("FAIL full_deq: got count=%0d head=%h want 3/00000064", iqueue_count, iqueue_o.pc); end
        step(0, 0, 0, 0, '0, '0);
        n_checks++; if (inst_read !== 1'b1 || inst_addr !== 32'h70) begin n_errors++; $display("FAIL full_refetch: got read=%b addr=%h want 1/00000070", inst_read, inst_addr); end
    endtask

    task automatic test_flush_outstanding();
        do_reset();
        step(0, 0, 0, 0, '0, '0);
        step(0, 1, 0, 0, '0, 32'h1111_1111);
        step(0, 0, 1, 0, 32'h200, '0);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (inst_read !== 1'b1 || inst_addr !== 32'h64 || iqueue_count !== '0) begin n_errors++; $display("FAIL drop_hold%0d: got read=%b addr=%h count=%0d want 1/00000064/0", i, inst_read, inst_addr, iqueue_count); end
            step(0, 0, 0, 0, '0, '0);
        end
        step(0, 1, 0, 0, '0, 32'hDEAD_BEEF);
        n_checks++; if (inst_read !== 1'b0 || inst_addr !== 32'h200 || iqueue_count !== '0) begin n_errors++; $display("FAIL drop_resp: got read=%b addr=%h count=%0d want 0/00000200/0", inst_read, inst_addr, iqueue_count); end
        step(0, 0, 0, 0, '0, '0);
        n_checks++; if (inst_read !== 1'b1 || inst_addr !== 32'h200) begin n_errors++; $display("FAIL drop_refetch: got read=%b addr=%h want 1/00000200", inst_read, inst_addr); end
        // A second flush while squashed replaces the pending target.
        step(0, 0, 1, 0, 32'h500, '0);
        step(0, 0, 1, 0, 32'h600, '0);
        step(0, 1, 0, 0, '0, 32'h2222_2222);
        n_checks++; if (inst_addr !== 32'h600 || iqueue_count !== '0) begin n_errors++; $display("FAIL drop_overwrite: got addr=%h count=%0d want 00000600/0", inst_addr, iqueue_count); end
    endtask

    task automatic test_flush_coincident();
        step(0, 0, 0, 0, '0, '0);
        step(0, 1, 1, 0, 32'h400, 32'h3333_3333);
        n_checks++; if (iqueue_count !== '0 || inst_read !== 1'b0 || inst_addr !== 32'h400) begin n_errors++; $display("FAIL coinc: got count=%0d read=%b addr=%h want 0/0/00000400", iqueue_count, inst_read, inst_addr); end
        step(0, 0, 1, 0, 32'h700, '0);
        n_checks++; if (inst_read !== 1'b0 || inst_addr !== 32'h700) begin n_errors++; $display("FAIL idle_flush: got read=%b addr=%h want 0/00000700", inst_read, inst_addr); end
        step(0, 0, 0, 0, '0, '0);
        n_checks++; if (inst_read !== 1'b1 || inst_addr !== 32'h700) begin n_errors++; $display("FAIL idle_flush_req: got read=%b addr=%h want 1/00000700", inst_read, inst_addr); end
    endtask

    task automatic test_back_to_back();
        step(0, 1, 0, 0, '0, 32'hAAAA_0000);
        step(0, 1, 0, 0, '0, 32'hAAAA_0001);
        n_checks++; if (iqueue_count !== CW'(2) || iqueue_o.pc !== 32'h700) begin n_errors++; $display("FAIL b2b_fill: got count=%0d head=%h want 2/00000700", iqueue_count, iqueue_o.pc); end
        step(0, 1, 0, 1, '0, 32'hAAAA_0002);
        n_checks++; if (iqueue_count !== CW'(2) || iqueue_o.pc !== 32'h704 || iqueue_o.instr !== 32'hAAAA_0001) begin n_errors++; $display("FAIL b2b_simul: got count=%0d head=%h/%h want 2/00000704/aaaa0001", iqueue_count, iqueue_o.pc, iqueue_o.instr); end
        step(0, 0, 0, 1, '0, '0);
        step(0, 0, 0, 1, '0, '0);
        step(0, 0, 0, 1, '0, '0);
        n_checks++; if (iqueue_count !== '0 || iqueue_valid !== 1'b0) begin n_errors++; $display("FAIL empty_read: got count=%0d valid=%b want 0/0", iqueue_count, iqueue_valid); end
        // The head slot after the empty read must be the next enqueued entry.
        step(0, 1, 0, 0, '0, 32'hBBBB_0000);
        n_checks++; if (iqueue_o.pc !== 32'h70C || iqueue_o.instr !== 32'hBBBB_0000) begin n_errors++; $display("FAIL empty_read_ptr: got %h/%h want 0000070c/bbbb0000", iqueue_o.pc, iqueue_o.instr); end
    endtask

    task automatic test_pc_wrap();
        step(0, 1, 1, 0, 32'hFFFF_FFFC, '0);
        step(0, 0, 0, 0, '0, '0);
        step(0, 1, 0, 0, '0, 32'h0000_0013);
        n_checks++; if (inst_addr !== 32'h0 || iqueue_o.pc !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL pc_wrap: got addr=%h head=%h want 00000000/fffffffc", inst_addr, iqueue_o.pc); end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 1, 0, 32'h80, '0);
        step(0, 0, 0, 0, '0, '0);
        n_checks++; if (inst_read !== 1'b1 || inst_addr !== 32'h80) begin n_errors++; $display("FAIL rstmid_setup: got read=%b addr=%h want 1/00000080", inst_read, inst_addr); end
        step(1, 0, 0, 0, '0, '0);
        n_checks++; if (inst_read !== 1'b0 || iqueue_count !== '0) begin n_errors++; $display("FAIL rstmid: got read=%b count=%0d want 0/0", inst_read, iqueue_count); end
        step(0, 1, 0, 0, '0, 32'h4444_4444);
        n_checks++; if (inst_read !== 1'b1 || inst_addr !== 32'h60 || iqueue_count !== '0) begin n_errors++; $display("FAIL rstmid_stale: got read=%b addr=%h count=%0d want 1/00000060/0", inst_read, inst_addr, iqueue_count); end
    endtask

    task automatic test_random();
        bit r_resp, r_flush, r_read;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r_resp  = m_busy && ($urandom_range(0, 2) != 0);
            r_flush = ($urandom_range(0, 15) == 0);
            if (m_drop && r_resp) r_flush = 0;
            r_read  = ($urandom_range(0, 2) == 0);
            step(0, r_resp, r_flush, r_read, $urandom() & 32'hFFFF_FFFC, $urandom());
            n_checks++; if (inst_read !== m_busy || inst_addr !== m_pc) begin n_errors++; $display("FAIL rand_fetch@%0d: got %b/%h want %b/%h", cyc, inst_read, inst_addr, m_busy, m_pc); end
            n_checks++; if (iqueue_count !== CW'(m_q.size()) || iqueue_valid !== (m_q.size() != 0)) begin n_errors++; $display("FAIL rand_count@%0d: got %0d/%b want %0d", cyc, iqueue_count, iqueue_valid, m_q.size()); end
            if (m_q.size() != 0) begin
                n_checks++; if (iqueue_o !== m_q[0]) begin n_errors++; $display("FAIL rand_head@%0d: got %h want %h", cyc, iqueue_o, m_q[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_full();
        test_flush_outstanding();
        test_flush_coincident();
        test_back_to_back();
        test_pc_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_queue
